mio_timer_bank: RTL

//   NCH-channel, memory-mapped down-counter/timer bank for the single-cycle SoC.

---
 rtl/mio_timer_bank.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mio_timer_bank.sv
// Memory-mapped bank of NCH prescaled down-counters with one-shot, auto-reload and
// square-wave modes, W1C done status and a registered combined interrupt.
module mio_timer_bank #(
    parameter int unsigned NCH   = 3,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PSC_W = 8,
    parameter int unsigned AW    = 5
) (
    input  logic           clk,
    input  logic           RSTN,
    input  logic           we,
    input  logic           re,
    input  logic [AW-1:0]  addr,
    input  logic [31:0]    wdata,
    output logic [31:0]    rdata,
    output logic           rvalid,
    output logic [NCH-1:0] tick_out,
    output logic           irq
);
    localparam int unsigned CHW = AW - 2;
    localparam logic [AW-1:0] IRQSUM_ADDR = AW'(4 * NCH);
    localparam logic [1:0] R_LOAD = 2'd0, R_CTRL = 2'd1, R_STATUS = 2'd3;
    localparam logic [1:0] R_COUNT = 2'd2;
    localparam logic [1:0] M_ONESHOT = 2'd0, M_RELOAD = 2'd1, M_SQUARE = 2'd2, M_HOLD = 2'd3;

    logic [NCH-1:0][WIDTH-1:0] load_q, load_d;
    logic [NCH-1:0][WIDTH-1:0] count_q, count_d;
    logic [NCH-1:0][PSC_W-1:0] psc_q, psc_d;
    logic [NCH-1:0][PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [NCH-1:0][1:0]       mode_q, mode_d;
    logic [NCH-1:0]            en_q, en_d;
    logic [NCH-1:0]            irq_en_q, irq_en_d;
    logic [NCH-1:0]            done_q, done_d;
    logic [NCH-1:0]            tick_q, tick_d;
    logic                      irq_q, irq_d;
    logic                      rvalid_q, rvalid_d;
    logic [31:0]               rdata_q, rdata_d;

    logic [NCH-1:0] sel_c, active_c, tick_c, ctrl_wr_c, stop_c, start_c;
    logic [NCH-1:0] term_c, w1c_c, load_wr_c;
    logic [31:0]    rd_mux_c;

    // Per-channel bus decode and prescaler/terminal-event detection
    always_comb begin
        sel_c     = '0;
        active_c  = '0;
        tick_c    = '0;
        ctrl_wr_c = '0;
        stop_c    = '0;
        start_c   = '0;
        term_c    = '0;
        w1c_c     = '0;
        load_wr_c = '0;
        for (int i = 0; i < NCH; i++) begin
            sel_c[i]     = (addr[AW-1:2] == CHW'(i));
            active_c[i]  = en_q[i] && (mode_q[i] != M_HOLD);
            tick_c[i]    = active_c[i] && (psc_cnt_q[i] >= psc_q[i]);
            ctrl_wr_c[i] = we && sel_c[i] && (addr[1:0] == R_CTRL);
            load_wr_c[i] = we && sel_c[i] && (addr[1:0] == R_LOAD);
            w1c_c[i]     = we && sel_c[i] && (addr[1:0] == R_STATUS) && wdata[0];
            stop_c[i]    = ctrl_wr_c[i] && !wdata[0];
            start_c[i]   = ctrl_wr_c[i] && wdata[0] && !en_q[i];
            // A CTRL write that clears en freezes the channel before this edge's step
            term_c[i]    = tick_c[i] && (count_q[i] == '0) && !stop_c[i];
        end
    end

    // Read mux sees pre-update state, so a same-cycle write returns the old value
    always_comb begin
        rd_mux_c = '0;
        if (addr == IRQSUM_ADDR) begin
            rd_mux_c = 32'(done_q & irq_en_q);
        end
        for (int i = 0; i < NCH; i++) begin
            if (sel_c[i]) begin
                case (addr[1:0])
                    R_LOAD:  rd_mux_c = 32'(load_q[i]);
                    R_CTRL: begin
                        rd_mux_c[0]          = en_q[i];
                        rd_mux_c[2:1]        = mode_q[i];
                        rd_mux_c[3]          = irq_en_q[i];
                        rd_mux_c[8 +: PSC_W] = psc_q[i];
                    end
                    R_COUNT: rd_mux_c = 32'(count_q[i]);
                    default: rd_mux_c = 32'(done_q[i]);
                endcase
            end
        end
    end

    // Next-state for counters, control, status and outputs
    always_comb begin
        load_d    = load_q;
        count_d   = count_q;
        psc_d     = psc_q;
        psc_cnt_d = psc_cnt_q;
        mode_d    = mode_q;
        en_d      = en_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        tick_d    = tick_q;
        for (int i = 0; i < NCH; i++) begin
            if (load_wr_c[i]) begin
                load_d[i] = wdata[WIDTH-1:0];
            end
            if (active_c[i] && !stop_c[i]) begin
                if (tick_c[i]) begin
                    psc_cnt_d[i] = '0;
                    if (count_q[i] != '0) begin
                        count_d[i] = count_q[i] - WIDTH'(1);
                    end else if (mode_q[i] == M_ONESHOT) begin
                        en_d[i] = 1'b0;
                    end else begin
                        count_d[i] = load_q[i];
                    end
                end else begin
                    psc_cnt_d[i] = psc_cnt_q[i] + PSC_W'(1);
                end
            end
            if (ctrl_wr_c[i]) begin
                mode_d[i]   = wdata[2:1];
                irq_en_d[i] = wdata[3];
                psc_d[i]    = wdata[8 +: PSC_W];
                if (stop_c[i]) begin
                    en_d[i] = 1'b0;
                end
                if (start_c[i]) begin
                    en_d[i]      = 1'b1;
                    count_d[i]   = load_q[i];
                    psc_cnt_d[i] = '0;
                end
            end
            done_d[i] = (done_q[i] && !w1c_c[i]) || term_c[i];
            case (mode_q[i])
                M_ONESHOT, M_RELOAD: tick_d[i] = term_c[i];
                M_SQUARE:            tick_d[i] = tick_q[i] ^ term_c[i];
                default:             tick_d[i] = tick_q[i];
            endcase
        end
        irq_d    = |(done_q & irq_en_q);
        rvalid_d = re;
        rdata_d  = re ? rd_mux_c : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            load_q    <= '0;
            count_q   <= '0;
            psc_q     <= '0;
            psc_cnt_q <= '0;
            mode_q    <= '0;
            en_q      <= '0;
            irq_en_q  <= '0;
            done_q    <= '0;
            tick_q    <= '0;
            irq_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            load_q    <= load_d;
            count_q   <= count_d;
            psc_q     <= psc_d;
            psc_cnt_q <= psc_cnt_d;
            mode_q    <= mode_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            tick_q    <= tick_d;
            irq_q     <= irq_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign tick_out = tick_q;
    assign irq      = irq_q;

endmodule
